// File: rtl/frag_rr_arb_if.sv
// frag_rr_arb_if: hit-lane input bundle and z-buffer output port of the fragment arbiter
interface frag_rr_arb_if #(
  parameter int SIGFIG = 24,
  parameter int AXIS = 3,
  parameter int COLORS = 3,
  parameter int LANES = 4
);
  localparam int LW = $clog2(LANES);
  logic signed [LANES-1:0][AXIS-1:0][SIGFIG-1:0] hit_R18S;
  logic [LANES-1:0][COLORS-1:0][SIGFIG-1:0] color_R18U;
  logic [LANES-1:0] hit_valid_R18H;
  logic [LANES-1:0] hit_ready_R18H;
  logic signed [AXIS-1:0][SIGFIG-1:0] hit_R19S;
  logic [COLORS-1:0][SIGFIG-1:0] color_R19U;
  logic [LW-1:0] lane_R19U;
  logic hit_valid_R19H;
  logic zb_ready_R19H;
  logic idle_RnnnnH;
  modport master (
    output hit_R18S, color_R18U, hit_valid_R18H, zb_ready_R19H,
    input hit_ready_R18H, hit_R19S, color_R19U, lane_R19U, hit_valid_R19H, idle_RnnnnH
  );
  modport slave (
    input hit_R18S, color_R18U, hit_valid_R18H, zb_ready_R19H,
    output hit_ready_R18H, hit_R19S, color_R19U, lane_R19U, hit_valid_R19H, idle_RnnnnH
  );
endinterface

// File: rtl/frag_rr_arb.sv
// frag_rr_arb: per-lane hit FIFOs drained round-robin into one registered z-buffer port.
// Defining FRAG_ARB_STATS_EN adds per-lane grant counters and a stall-cycle counter.
module frag_rr_arb #(
  parameter int SIGFIG = 24,
  parameter int AXIS = 3,
  parameter int COLORS = 3,
  parameter int LANES = 4,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  frag_rr_arb_if.slave bus
`ifdef FRAG_ARB_STATS_EN
  ,
  output logic [LANES-1:0][31:0] grant_cnt_RnnnnU,
  output logic [31:0] stall_cnt_RnnnnU
`endif
);
  localparam int LW = $clog2(LANES);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = AXIS * SIGFIG;
  localparam int FW = (AXIS + COLORS) * SIGFIG;
  logic [FW-1:0] mem [LANES][DEPTH];
  logic [CW-1:0] cnt [LANES];
  logic [PW-1:0] wp [LANES];
  logic [PW-1:0] rp [LANES];
  logic [LANES-1:0] empty, push, pop;
  logic [LW-1:0] last, grant, lane_q;
  logic [FW-1:0] out_q;
  logic valid_q, load_en, found;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign empty[g] = cnt[g] == '0;
    assign bus.hit_ready_R18H[g] = cnt[g] != CW'(DEPTH);
  end
  assign push = bus.hit_valid_R18H & bus.hit_ready_R18H;
  assign load_en = !valid_q || bus.zb_ready_R19H;
  // search starts one past the last grant so every lane gets a turn
  always_comb begin
    found = 1'b0;
    grant = last;
    for (int k = 1; k <= LANES; k++)
      if (!found && !empty[(int'(last) + k) % LANES]) begin
        found = 1'b1;
        grant = LW'((int'(last) + k) % LANES);
      end
  end
  assign pop = (load_en && found) ? LANES'(1) << grant : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < LANES; i++) begin
        cnt[i] <= '0;
        wp[i] <= '0;
        rp[i] <= '0;
      end
    else
      for (int i = 0; i < LANES; i++) begin
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
        if (push[i]) wp[i] <= wp[i] + 1'b1;
        if (pop[i]) rp[i] <= rp[i] + 1'b1;
      end
  always_ff @(posedge clk)
    for (int i = 0; i < LANES; i++)
      if (push[i]) mem[i][wp[i]] <= {bus.hit_R18S[i], bus.color_R18U[i]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= 1'b0;
      out_q <= '0;
      lane_q <= '0;
      last <= LW'(LANES - 1);
    end else if (load_en) begin
      valid_q <= found;
      if (found) begin
        out_q <= mem[grant][rp[grant]];
        lane_q <= grant;
        last <= grant;
      end
    end
  assign bus.hit_valid_R19H = valid_q;
  assign bus.lane_R19U = lane_q;
  assign bus.hit_R19S = out_q[FW-1 -: HW];
  assign bus.color_R19U = out_q[FW-HW-1:0];
  assign bus.idle_RnnnnH = &empty && !valid_q;
`ifdef FRAG_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      grant_cnt_RnnnnU <= '0;
      stall_cnt_RnnnnU <= '0;
    end else begin
      if (valid_q && bus.zb_ready_R19H) grant_cnt_RnnnnU[lane_q] <= grant_cnt_RnnnnU[lane_q] + 32'd1;
      if (valid_q && !bus.zb_ready_R19H) stall_cnt_RnnnnU <= stall_cnt_RnnnnU + 32'd1;
    end
`endif
endmodule

// File: tb/tb_frag_rr_arb.sv
// tb_frag_rr_arb: randomized scoreboard bench for frag_rr_arb against a queue-based lane model
module tb_frag_rr_arb;
  localparam int SIGFIG = 24, AXIS = 3, COLORS = 3, LANES = 4, DEPTH = 4;
  localparam int LW = $clog2(LANES);
  localparam int HW = AXIS * SIGFIG;
  localparam int FW = (AXIS + COLORS) * SIGFIG;
  typedef struct {
    logic [FW-1:0] d;
    int c;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  frag_rr_arb_if #(.SIGFIG(SIGFIG), .AXIS(AXIS), .COLORS(COLORS), .LANES(LANES)) bus ();
`ifdef FRAG_ARB_STATS_EN
  logic [LANES-1:0][31:0] gc;
  logic [31:0] sc;
`endif
  frag_rr_arb #(.SIGFIG(SIGFIG), .AXIS(AXIS), .COLORS(COLORS), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FRAG_ARB_STATS_EN
    ,
    .grant_cnt_RnnnnU(gc),
    .stall_cnt_RnnnnU(sc)
`endif
  );
  int cyc = 0;
  int vectors = 0;
  int errors = 0;
  ent_t q[LANES][$];
  logic exp_v = 1'b0;
  logic [LW-1:0] exp_lane = '0;
  logic [FW-1:0] exp_d = '0;
  int last_m = LANES - 1;
  int m_grant[LANES];
  int m_stall = 0;
  int occ, g;
  logic all_empty;
  logic [LANES-1:0] exp_rdy;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask
  function automatic logic [FW-1:0] rand_frag();
    logic [FW-1:0] f;
    for (int i = 0; i < FW; i += 8) f[i +: 8] = 8'($urandom);
    return f;
  endfunction
  // reference: lane queues tagged with push cycle; a push becomes eligible one cycle after it lands
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        q[i].delete();
        m_grant[i] = 0;
      end
      m_stall = 0;
      exp_v = 1'b0;
      last_m = LANES - 1;
      chk("rst_valid", FW'(bus.hit_valid_R19H), '0);
      chk("rst_ready", FW'(bus.hit_ready_R18H), FW'({LANES{1'b1}}));
      chk("rst_idle", FW'(bus.idle_RnnnnH), FW'(1));
      chk("rst_lane", FW'(bus.lane_R19U), '0);
      chk("rst_data", {bus.hit_R19S, bus.color_R19U}, '0);
    end else begin
      chk("valid", FW'(bus.hit_valid_R19H), FW'(exp_v));
      if (exp_v) begin
        chk("lane", FW'(bus.lane_R19U), FW'(exp_lane));
        chk("data", {bus.hit_R19S, bus.color_R19U}, exp_d);
      end
      all_empty = 1'b1;
      for (int i = 0; i < LANES; i++) begin
        occ = 0;
        foreach (q[i][j]) if (q[i][j].c < cyc) occ++;
        exp_rdy[i] = occ < DEPTH;
        if (occ != 0) all_empty = 1'b0;
      end
      chk("ready", FW'(bus.hit_ready_R18H), FW'(exp_rdy));
      chk("idle", FW'(bus.idle_RnnnnH), FW'(all_empty && !exp_v));
      if (exp_v && bus.zb_ready_R19H) m_grant[exp_lane]++;
      if (exp_v && !bus.zb_ready_R19H) m_stall++;
      if (!exp_v || bus.zb_ready_R19H) begin
        g = -1;
        for (int k = 1; k <= LANES; k++) begin
          occ = (last_m + k) % LANES;
          if (g < 0 && q[occ].size() > 0 && q[occ][0].c < cyc) g = occ;
        end
        exp_v = g >= 0;
        if (g >= 0) begin
          exp_d = q[g].pop_front().d;
          exp_lane = LW'(g);
          last_m = g;
        end
      end
    end
  end
  task automatic drive(input logic [LANES-1:0] v, input logic zr, input logic [FW-1:0] fixed = '0);
    logic [FW-1:0] f;
    @(posedge clk);
    #2;
    for (int i = 0; i < LANES; i++) begin
      f = (fixed != '0) ? fixed : rand_frag();
      bus.hit_R18S[i] = f[FW-1 -: HW];
      bus.color_R18U[i] = f[FW-HW-1:0];
      if (v[i] && bus.hit_ready_R18H[i]) q[i].push_back('{d: f, c: cyc});
    end
    bus.hit_valid_R18H = v;
    bus.zb_ready_R19H = zr;
  endtask
  initial begin
    logic [FW-1:0] single;
    single = {24'h000123, 24'h000045, 24'h000C00, 24'hABCDEF, 24'h123456, 24'h800001};
    bus.hit_R18S = '0;
    bus.color_R18U = '0;
    bus.hit_valid_R18H = '0;
    bus.zb_ready_R19H = 1'b1;
    repeat (3) drive('0, 1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    drive(4'b0100, 1'b1, single);
    repeat (5) drive('0, 1'b1);
    repeat (30) drive('1, 1'b1);
    repeat (8) drive('0, 1'b1);
    repeat (10) drive(4'b0001, 1'b0);
    repeat (12) drive('0, 1'b1);
    repeat (4) drive(4'b1010, 1'b1);
    repeat (6) drive('0, 1'b1);
    repeat (8) drive(4'b0010, 1'b1);
    repeat (4) drive('0, 1'b0);
    repeat (8) drive('0, 1'b1);
    repeat (500) drive(LANES'($urandom), $urandom_range(0, 3) != 0);
    repeat (3) drive(4'b0111, 1'b0);
    #1 rst = 1'b1;
    bus.hit_valid_R18H = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (3) drive(4'b1111, 1'b1);
    for (int n = 0; n < 100 && !bus.idle_RnnnnH; n++) drive('0, 1'b1);
    @(negedge clk);
    chk("drain_idle", FW'(bus.idle_RnnnnH), FW'(1));
`ifdef FRAG_ARB_STATS_EN
    for (int i = 0; i < LANES; i++) chk("grant_cnt", FW'(gc[i]), FW'(32'(m_grant[i])));
    chk("stall_cnt", FW'(sc), FW'(32'(m_stall)));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/frag_rr_arb.md
# frag_rr_arb

Round-robin fragment arbiter placed between the four sample-test hit lanes (R18) and the single-ported z-buffer write stage (R19). Each lane's hit fragment (position, depth, color) is captured into a per-lane FIFO. One fragment per cycle is forwarded through a registered valid/ready output port, with fair round-robin selection among non-empty lanes. An idle flag tells the bench when the arbiter is drained, so the final image write is safe.

## Interface
- SIGFIG, 24, bits per position/color word
- AXIS, 3, axes per hit (x, y, z)
- COLORS, 3, color channels
- LANES, 4, number of hit lanes
- DEPTH, 4, entries per lane FIFO (power of two, ≥2)
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- hit_R18S  input  [LANES][AXIS][SIGFIG] signed  per-lane hit position/depth
- color_R18U  input  [LANES][COLORS][SIGFIG]  per-lane hit color
- hit_valid_R18H  input  [LANES]  lane fragment valid
- hit_ready_R18H  output  [LANES]  lane FIFO not full
- hit_R19S  output  [AXIS][SIGFIG] signed  selected fragment position/depth
- color_R19U  output  [COLORS][SIGFIG]  selected fragment color
- lane_R19U  output  clog2(LANES)  source lane of output fragment
- hit_valid_R19H  output  1  output fragment valid
- zb_ready_R19H  input  1  z-buffer accepts fragment
- idle_RnnnnH  output  1  all FIFOs and output register empty

## Operation
- Lane push: occurs when hit_valid_R18H[i] && hit_ready_R18H[i]. Data is written at FIFO write pointer. Valid without ready is ignored; upstream holds the fragment.
- hit_ready_R18H[i] = !full[i]. It is based on the registered count only. A full FIFO refuses push even in a cycle where it pops.
- Each FIFO uses a count of clog2(DEPTH)+1 bits and read/write pointers that wrap modulo DEPTH. Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Output register load enable: load_en = !hit_valid_R19H || zb_ready_R19H.
- Arbiter: when load_en is high and any FIFO is non-empty, grant the first non-empty lane in order last+1, last+2, …, last (modulo LANES). Then pop that lane, load the output register, and set last = grant.
- No eligible lane while load_en is high: clear hit_valid_R19H.
- Output hold: while hit_valid_R19H && !zb_ready_R19H, the output register and lane_R19U stay stable and no pop occurs.
- last resets to LANES-1, so lane 0 has the first priority after reset.
- idle_RnnnnH = all counts zero && !hit_valid_R19H. It is combinational from registers.
- Fragment fields pass through unmodified, with no sign or width change.

## Timing
- Reset values:
  - hit_valid_R19H = 0
  - hit_R19S, color_R19U, lane_R19U = 0
  - all FIFO counts and pointers = 0
  - hit_ready_R18H = all ones
  - idle_RnnnnH = 1
- Reset asserted mid-operation discards all buffered and in-flight fragments immediately (asynchronous). Outputs return to their reset values.
- Latency: a fragment pushed in cycle c appears on hit_valid_R19H in cycle c+2 at the earliest (FIFO write at end of c, grant in c+1).
- Throughput: one fragment per cycle while zb_ready_R19H is held high and any FIFO is non-empty.
- Fairness: with all lanes continuously non-empty, each lane is granted exactly once in every LANES consecutive grants.
- Starvation bound: a non-empty lane waits at most LANES-1 grants.

## Configuration
- FRAG_ARB_STATS_EN defined adds two outputs:
  - grant_cnt_RnnnnU [LANES][32]: per-lane accepted-fragment counters, incremented when a lane's fragment is accepted (hit_valid_R19H && zb_ready_R19H).
  - stall_cnt_RnnnnU [32]: counts cycles with hit_valid_R19H && !zb_ready_R19H.
  - All counters reset to 0 and wrap at 2^32.
- FRAG_ARB_STATS_EN undefined: those ports and their logic are absent. All other behaviour is identical.

## Test plan
- Single fragment: lane 2 pushes x=0x000C00, zb_ready held 1, at cycle 0.
  - hit_valid_R19H high in cycle 2 only, carrying the unmodified fields.
  - lane_R19U=2; idle_RnnnnH returns to 1 in cycle 3.
- All four lanes push every cycle with zb_ready=1 → lane_R19U sequence 0,1,2,3,0,1,… with no gaps.
- zb_ready=0 for 10 cycles while lane 0 pushes continuously:
  - hit_ready_R18H[0] drops after DEPTH accepted pushes plus the one held in the output register.
  - The output stays stable throughout.
  - After release, fragments drain in push order.
- Lanes 1 and 3 only non-empty, with last=1 → next grant is 3, then 1. Empty lanes are skipped with no bubble.
- rst asserted asynchronously with 3 fragments buffered → next cycle hit_valid_R19H=0, all ready high, idle=1. Post-reset priority is lane 0.
- With FRAG_ARB_STATS_EN: 8 fragments on lane 1 and 4 stall cycles → grant_cnt[1]=8, stall_cnt=4, other lane counts 0.
